// File: rtl/msg_pkg.sv
// Shared constants for the scrolling-message display: character codes,
// active-low glyphs and the power-on message.
package msg_pkg;

    localparam int unsigned CHAR_W = 3;
    localparam int unsigned SEG_W  = 7;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [SEG_W-1:0]  seg_t;

    localparam char_t CH_H     = 3'b000;
    localparam char_t CH_E     = 3'b001;
    localparam char_t CH_L     = 3'b010;
    localparam char_t CH_O     = 3'b011;
    localparam char_t CH_BLANK = 3'b111;

    // Segment order g..a, bit 0 = a, 0 = lit
    localparam seg_t SEG_H     = 7'b0001001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_L     = 7'b1000111;
    localparam seg_t SEG_O     = 7'b1000000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Power-on buffer contents: HELLO followed by blanks
    function automatic char_t reset_char(input int unsigned idx);
        char_t c;
        case (idx)
            0:       c = CH_H;
            1:       c = CH_E;
            2:       c = CH_L;
            3:       c = CH_L;
            4:       c = CH_O;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/char_to_seg.sv
// Character code to active-low 7-segment glyph; codes 100-111 are blank.
module char_to_seg
    import msg_pkg::*;
(
    input  logic [CHAR_W-1:0] code_i,
    output logic [SEG_W-1:0]  seg_c_o
);

    always_comb begin
        seg_c_o = SEG_BLANK;
        case (code_i)
            CH_H:    seg_c_o = SEG_H;
            CH_E:    seg_c_o = SEG_E;
            CH_L:    seg_c_o = SEG_L;
            CH_O:    seg_c_o = SEG_O;
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolling-message controller: 8-entry character buffer viewed through a
// rotating window, advanced by a programmable tick or a manual step edge.
module msg_scroller
    import msg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          dir,
    input  logic                          step,
    input  logic                          wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]    wr_addr,
    input  logic [CHAR_W-1:0]             wr_char,
    output logic [CHAR_W*NUM_DIGITS-1:0]  code_out,
    output logic [SEG_W*NUM_DIGITS-1:0]   hex_n,
    output logic                          shift_pulse
);

    localparam int unsigned AW     = $clog2(MSG_LEN);
    localparam int unsigned CW     = $clog2(TICK_DIV);
    localparam int unsigned CODE_W = CHAR_W * NUM_DIGITS;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_c;
    logic              step_q;
    logic              step_req_c;
    logic              shift_c;
    logic [AW-1:0]     head_q, head_d;
    char_t             msg_q [MSG_LEN];
    char_t             msg_d [MSG_LEN];
    logic [CODE_W-1:0] code_q, code_d;
    logic              pulse_q;

    // Tick divider: held at zero while run is low
    always_comb begin
        tick_c = run && (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = '0;
        if (run && !tick_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign step_req_c = step & ~step_q;
    assign shift_c    = tick_c | step_req_c;

    // Next head, next buffer and the window over them
    always_comb begin
        head_d = head_q;
        if (shift_c) begin
            head_d = dir ? head_q - AW'(1) : head_q + AW'(1);
        end

        msg_d = msg_q;
        if (wr_en) begin
            msg_d[wr_addr] = wr_char;
        end

        code_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            code_d[CHAR_W*(NUM_DIGITS-1-i) +: CHAR_W] = msg_d[head_d + AW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            step_q  <= 1'b0;
            head_q  <= '0;
            pulse_q <= 1'b0;
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= reset_char(i);
            end
            code_q <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                code_q[CHAR_W*(NUM_DIGITS-1-i) +: CHAR_W] <= reset_char(i);
            end
        end else begin
            cnt_q   <= cnt_d;
            step_q  <= step;
            head_q  <= head_d;
            pulse_q <= shift_c;
            msg_q   <= msg_d;
            code_q  <= code_d;
        end
    end

    assign code_out    = code_q;
    assign shift_pulse = pulse_q;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        char_to_seg u_seg (
            .code_i  (code_q[CHAR_W*k +: CHAR_W]),
            .seg_c_o (hex_n[SEG_W*k +: SEG_W])
        );
    end

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: directed scenarios then random traffic
// against a message/head reference model.
module tb_msg_scroller;

    localparam int ND = 5;
    localparam int ML = 8;
    localparam int TD = 4;

    localparam logic [14:0] HELLO = 15'b000_001_010_010_011;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        run     = 1'b0;
    logic        dir     = 1'b0;
    logic        step    = 1'b0;
    logic        wr_en   = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [2:0]  wr_char = 3'd0;
    logic [14:0] code_out;
    logic [34:0] hex_n;
    logic        shift_pulse;

    int errors = 0;
    int checks = 0;
    int pulses;

    int m_buf [ML];
    int m_head;
    int m_cnt;
    bit m_step_prev;
    bit m_pulse;

    msg_scroller #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .dir         (dir),
        .step        (step),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .code_out    (code_out),
        .hex_n       (hex_n),
        .shift_pulse (shift_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [2:0] c);
        case (c)
            3'b000:  return 7'b0001001;
            3'b001:  return 7'b0000110;
            3'b010:  return 7'b1000111;
            3'b011:  return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leftmost digit shows logical position 0 of the message
    function automatic logic [14:0] model_code();
        logic [14:0] c = '0;
        for (int i = 0; i < ND; i++) begin
            c[3*(ND-1-i) +: 3] = 3'(m_buf[(m_head + i) % ML]);
        end
        return c;
    endfunction

    function automatic logic [34:0] model_hex();
        logic [14:0] c = model_code();
        logic [34:0] h = '0;
        for (int k = 0; k < ND; k++) begin
            h[7*k +: 7] = glyph(c[3*k +: 3]);
        end
        return h;
    endfunction

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_buf       = '{0, 1, 2, 2, 3, 7, 7, 7};
        m_head      = 0;
        m_cnt       = 0;
        m_step_prev = 1'b0;
        m_pulse     = 1'b0;
    endtask

    // Advance the model with the current inputs, clock once, compare all outputs
    task automatic cycle(input string tag);
        bit tk;
        bit req;
        tk  = run && (m_cnt == TD - 1);
        req = step && !m_step_prev;
        m_cnt = run ? (m_cnt + 1) % TD : 0;
        m_step_prev = step;
        if (tk || req) m_head = dir ? (m_head + ML - 1) % ML : (m_head + 1) % ML;
        if (wr_en) m_buf[wr_addr] = int'(wr_char);
        m_pulse = tk || req;
        @(posedge clk);
        #1;
        check({tag, ".code"},  35'(code_out),    35'(model_code()));
        check({tag, ".hex"},   hex_n,            model_hex());
        check({tag, ".pulse"}, 35'(shift_pulse), 35'(m_pulse));
        if (shift_pulse) pulses++;
    endtask

    initial begin
        model_reset();

        // Reset state
        #12;
        check("rst.code", 35'(code_out), 35'(HELLO));
        check("rst.hex4", 35'(hex_n[34:28]), 35'(7'b0001001));
        check("rst.pulse", 35'(shift_pulse), 35'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Auto-scroll left
        run = 1'b1;
        dir = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) cycle("auto");
        check("auto.first", 35'(code_out), 35'(15'b001_010_010_011_111));
        check("auto.first_pulse", 35'(pulses), 35'(1));
        for (int i = 0; i < 28; i++) cycle("auto");
        check("auto.wrap", 35'(code_out), 35'(HELLO));
        check("auto.count", 35'(pulses), 35'(8));

        // Manual step right wraps head to 7; held step shifts once
        run = 1'b0;
        dir = 1'b1;
        step = 1'b1;
        pulses = 0;
        cycle("rstep");
        check("rstep.code", 35'(code_out), 35'(15'b111_000_001_010_010));
        for (int i = 0; i < 10; i++) cycle("hold");
        check("hold.count", 35'(pulses), 35'(1));
        step = 1'b0;
        cycle("rel");

        // Step edge coincides with tick: single shift
        run = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 3; i++) cycle("coin");
        step = 1'b1;
        cycle("coin");
        check("coin.code", 35'(code_out), 35'(HELLO));
        step = 1'b0;

        // Write into buf[5] in the tick cycle
        for (int i = 0; i < 3; i++) cycle("wsh");
        wr_en = 1'b1;
        wr_addr = 3'd5;
        wr_char = 3'b011;
        cycle("wsh");
        check("wsh.code", 35'(code_out), 35'(15'b001_010_010_011_011));
        wr_en = 1'b0;

        // Dropping run restarts the full interval
        cycle("gate");
        cycle("gate");
        run = 1'b0;
        for (int i = 0; i < 5; i++) cycle("gate_off");
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) cycle("gate_on");
        check("gate.early", 35'(pulses), 35'(0));
        cycle("gate_on");
        check("gate.shift", 35'(shift_pulse), 35'(1));
        check("gate.code", 35'(code_out), 35'(15'b010_010_011_011_111));

        // Asynchronous reset mid-scroll
        cycle("pre_rst");
        cycle("pre_rst");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst.code", 35'(code_out), 35'(HELLO));
        check("mrst.hex4", 35'(hex_n[34:28]), 35'(7'b0001001));
        check("mrst.pulse", 35'(shift_pulse), 35'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b0;
        cycle("post_rst");
        cycle("post_rst");
        check("post_rst.code", 35'(code_out), 35'(HELLO));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            run     = ($urandom_range(0, 9) != 0);
            dir     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step = ~step;
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_char = 3'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_scroller.md
# msg_scroller

Scrolling-message controller for the board's bank of active-low 7-segment displays. It holds an 8-entry character buffer and rotates a display window across it on a programmable tick, or on a manual step. It drives one character code and one active-low segment vector per digit. It sits between the board switches/keys and the HEX outputs and replaces per-digit hardwired decoders at top level.

## Interface
- `NUM_DIGITS`, default 5: number of displays driven; 1..`MSG_LEN`.
- `MSG_LEN`, default 8: buffer depth; must be a power of two.
- `TICK_DIV`, default 50_000_000: clock cycles per automatic shift; must be ≥2.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `run`, in, 1: 1 enables automatic scrolling.
- `dir`, in, 1: 0 scrolls left (head+1), 1 scrolls right (head−1).
- `step`, in, 1: synchronous level; its rising edge requests one shift.
- `wr_en`, in, 1: write strobe, one cycle.
- `wr_addr`, in, log2(`MSG_LEN`): physical buffer index.
- `wr_char`, in, 3: character code to write.
- `code_out`, out, 3·`NUM_DIGITS`: registered codes, digit k at bits [3k+2:3k].
- `hex_n`, out, 7·`NUM_DIGITS`: active-low segments, digit k at [7k+6:7k], bit order g..a (bit 0 = a).
- `shift_pulse`, out, 1: one-cycle pulse in the cycle after head changes.

## Operation
- Character codes: H=000, E=001, L=010, O=011. Any value 100–111 is blank.
- Buffer `buf[0..MSG_LEN-1]` with a head pointer `head`.
  - Logical position i maps to `buf[(head+i) mod MSG_LEN]`.
  - Wrap is natural modulo 2^n.
- Display mapping: digit `NUM_DIGITS-1-i` shows logical position i, so the message reads left to right with digit `NUM_DIGITS-1` leftmost.
- Reset (asynchronous, takes effect mid-operation as well), all immediately:
  - `buf` = H,E,L,L,O, then blank (111) in the remaining entries.
  - `head` = 0; tick counter = 0; step edge register = 0; `shift_pulse` = 0.
  - `code_out` = reset display (default: 15'b000_001_010_010_011).
- Tick counter:
  - If `run`=0, it is held at 0.
  - If `run`=1, it counts 0..`TICK_DIV`-1; at `TICK_DIV`-1 it asserts `tick` and wraps to 0.
- Step request: `step` & ~`step_d`, where `step_d` is `step` registered.
- Shift condition: `tick` | step request.
  - Exactly one shift occurs per cycle, even when both fire together.
  - On a shift, `head` ← `head`+1 if `dir`=0, else `head`−1.
- Write: when `wr_en`=1, `buf[wr_addr]` ← `wr_char`.
  - A write is independent of a shift in the same cycle; both take effect.
- `code_out` is registered from next-state `buf`/`head`. It reflects any write or shift of cycle N at edge N+1, with no extra lag.
- `hex_n` is combinational from `code_out` through per-digit decoders.
  - Glyphs: H=0001001, E=0000110, L=1000111, O=1000000, blank=1111111.

## Timing
- Automatic shift: with `run` held high from the reset release, the first shift occurs at the `TICK_DIV`-th rising edge. Later shifts follow every `TICK_DIV` cycles.
- Dropping `run` clears the counter; raising it again restarts the full `TICK_DIV` interval.
- Step latency: `step` rises before edge N → `head` and `code_out` updated at edge N → `shift_pulse` high during cycle N…N+1.
- A held `step` produces a single shift. It must fall and rise again for another.
- `dir` is sampled only in the shift cycle; changing it has no other effect.
- Write latency: `wr_en` at edge N → `code_out` shows the new character at edge N, if that entry is visible.
- No backpressure and no busy state; every request is accepted in its cycle.

## Structure
- Package `msg_pkg`:
  - Constants `CH_H`, `CH_E`, `CH_L`, `CH_O`, `CH_BLANK`.
  - Reset message contents.
  - Active-low glyph constants.
- Sub-module `char_to_seg`: 3-bit code in, 7-bit active-low segments out, purely combinational. Instantiated `NUM_DIGITS` times in a generate loop.
- Top contains the tick counter, step edge detect, head pointer, buffer register file and the window mux.

## Test plan
1. Reset values: assert `rst_n`=0 mid-scroll.
   - Immediately: `code_out`=000_001_010_010_011 and `hex_n` digit 4 = 0001001.
   - After release, `head`=0.
2. Auto-scroll: `TICK_DIV`=4, `run`=1, `dir`=0.
   - Expect shifts at edges 4, 8, 12.
   - After the first shift, the display reads E,L,L,O,blank (`code_out`=001_010_010_011_111).
   - After 8 shifts the display is back to HELLO.
3. Right wrap: `run`=0, `dir`=1, one `step` edge from `head`=0.
   - `head`=7; display reads blank,H,E,L,L.
   - `shift_pulse` is high exactly one cycle.
   - Holding `step` high for 10 cycles gives no further shift.
4. Coincidence: `TICK_DIV`=4, `step` rising in the same cycle as `tick` → exactly one shift (head +1, not +2).
5. Write during shift: `wr_en`=1, `wr_addr`=5, `wr_char`=CH_O in the tick cycle.
   - The next `code_out` shows both the shift and the new O at logical position 4 (digit 0).
6. Run gating: drop `run` at counter=2 for 5 cycles, then raise it → next shift exactly 4 cycles later.
